notebook_text_ctrl: RTL

- Sequences character writes onto the ruled notebook page drawn by the VGA sync/render block.
- Accepts characters over a valid/ready handshake and keeps a text cursor on the page's row/column grid.
- Issues single-cycle write commands to the character buffer, only during vertical blanking; also runs a full-page clear.
- Sits between the input source (keyboard/UART decoder) and the character buffer read by the renderer.

---
 rtl/notebook_pkg.sv | 26 ++
 rtl/notebook_text_ctrl_if.sv | 21 ++
 rtl/notebook_text_ctrl_page_clear_sweeper.sv | 35 +++
 rtl/notebook_text_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/notebook_pkg.sv
// rtl/notebook_pkg.sv - shared types and constants for the notebook text controller
package notebook_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BLANK,
        ST_WRITE_BS,
        ST_CLEAR
    } state_t;

    localparam logic [7:0] CHAR_NL        = 8'h0A;
    localparam logic [7:0] CHAR_BS        = 8'h08;
    localparam logic [7:0] CHAR_SPACE     = 8'h20;
    localparam logic [7:0] CHAR_PRINT_MIN = 8'h20;
    localparam logic [7:0] CHAR_PRINT_MAX = 8'h7E;

    localparam int DEF_ROWS  = 20;
    localparam int DEF_COLS  = 33;
    localparam int DEF_CELLS = DEF_ROWS * DEF_COLS;

    // Linear buffer index of a grid cell, row-major.
    function automatic int cell_index(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/notebook_text_ctrl_if.sv
// rtl/notebook_text_ctrl_if.sv - character handshake and buffer write bus
interface notebook_text_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              i_char_valid;
    logic [7:0]        i_char;
    logic              o_char_ready;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;

    modport master (
        output i_char_valid, i_char,
        input  o_char_ready, o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        input  i_char_valid, i_char,
        output o_char_ready, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/notebook_text_ctrl_page_clear_sweeper.sv
// rtl/notebook_text_ctrl_page_clear_sweeper.sv - blank-gated sweep counter for page clear
module page_clear_sweeper
    import notebook_pkg::*;
#(
    parameter int CELLS  = DEF_CELLS,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_vblank,
    output logic              o_step,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_done
);
    logic              r_active;
    logic [ADDR_W-1:0] r_index;

    assign o_step  = r_active && i_vblank;
    assign o_done  = o_step && (r_index == ADDR_W'(CELLS - 1));
    assign o_index = r_index;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_index  <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_index  <= '0;
        end else if (o_step) begin
            r_index <= o_done ? '0 : r_index + 1'b1;
            if (o_done) r_active <= 1'b0;
        end
    end
endmodule

// File: rtl/notebook_text_ctrl.sv
// rtl/notebook_text_ctrl.sv - cursor-tracking character writer for the ruled notebook page
module notebook_text_ctrl
    import notebook_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = 10
) (
    input  logic                     VGA_CLK_IN,
    input  logic                     VGA_RST_N,
    input  logic                     i_vblank,
    input  logic                     i_clear_req,
    notebook_text_ctrl_if.slave      bus,
    output logic [$clog2(ROWS)-1:0]  o_cursor_row,
    output logic [$clog2(COLS)-1:0]  o_cursor_col,
    output logic                     o_busy,
    output logic                     o_page_full
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    state_t            r_state, w_state_nxt;
    logic [ROW_W-1:0]  r_row, w_row_nxt;
    logic [COL_W-1:0]  r_col, w_col_nxt;
    logic [7:0]        r_char, w_char_nxt;
    logic              r_page_full, w_pf_nxt;
    logic              r_clear_pending, w_pend_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_addr_nxt;
    logic [7:0]        r_wr_data, w_data_nxt;
    logic              r_busy;

    logic              w_accept, w_printable, w_at_origin, w_clear_go, w_start;
    logic              w_step, w_done;
    logic [ADDR_W-1:0] w_sweep_idx, w_cur_addr;

    assign bus.o_char_ready = (r_state == ST_IDLE) && !r_page_full && !i_clear_req && !r_clear_pending;
    assign bus.o_wr_en      = r_wr_en;
    assign bus.o_wr_addr    = r_wr_addr;
    assign bus.o_wr_data    = r_wr_data;
    assign o_cursor_row     = r_row;
    assign o_cursor_col     = r_col;
    assign o_busy           = r_busy;
    assign o_page_full      = r_page_full;

    assign w_accept    = bus.i_char_valid && bus.o_char_ready;
    assign w_printable = (bus.i_char >= CHAR_PRINT_MIN) && (bus.i_char <= CHAR_PRINT_MAX);
    assign w_at_origin = (r_row == '0) && (r_col == '0);
    assign w_clear_go  = i_clear_req || r_clear_pending;
    assign w_cur_addr  = ADDR_W'(cell_index(int'(r_row), int'(r_col), COLS));

    page_clear_sweeper #(
        .CELLS  (ROWS * COLS),
        .ADDR_W (ADDR_W)
    ) u_sweeper (
        .clk      (VGA_CLK_IN),
        .rst_n    (VGA_RST_N),
        .i_start  (w_start),
        .i_vblank (i_vblank),
        .o_step   (w_step),
        .o_index  (w_sweep_idx),
        .o_done   (w_done)
    );

    always_ff @(posedge VGA_CLK_IN) begin
        if (!VGA_RST_N) begin
            r_state         <= ST_IDLE;
            r_row           <= '0;
            r_col           <= '0;
            r_char          <= '0;
            r_page_full     <= 1'b0;
            r_clear_pending <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_row           <= w_row_nxt;
            r_col           <= w_col_nxt;
            r_char          <= w_char_nxt;
            r_page_full     <= w_pf_nxt;
            r_clear_pending <= w_pend_nxt;
            r_wr_en         <= w_wr_en_nxt;
            r_wr_addr       <= w_addr_nxt;
            r_wr_data       <= w_data_nxt;
            r_busy          <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_clear_go)                                    w_state_nxt = ST_CLEAR;
                else if (w_accept && w_printable)                  w_state_nxt = ST_WAIT_BLANK;
                else if (w_accept && bus.i_char == CHAR_BS && !w_at_origin) w_state_nxt = ST_WRITE_BS;
            end
            ST_WAIT_BLANK, ST_WRITE_BS: if (i_vblank) w_state_nxt = ST_IDLE;
            ST_CLEAR:                   if (w_done)   w_state_nxt = ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_char_nxt  = r_char;
        w_pf_nxt    = r_page_full;
        w_pend_nxt  = r_clear_pending;
        w_wr_en_nxt = 1'b0;
        w_addr_nxt  = r_wr_addr;
        w_data_nxt  = r_wr_data;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_clear_go) begin
                    w_start = 1'b1;
                end else if (w_accept) begin
                    if (w_printable) begin
                        w_char_nxt = bus.i_char;
                    end else if (bus.i_char == CHAR_NL) begin
                        w_col_nxt = '0;
                        if (r_row < ROW_W'(ROWS - 1)) w_row_nxt = r_row + 1'b1;
                        else                          w_pf_nxt  = 1'b1;
                    end else if (bus.i_char == CHAR_BS && !w_at_origin) begin
                        if (r_col == '0) begin
                            w_col_nxt = COL_W'(COLS - 1);
                            w_row_nxt = r_row - 1'b1;
                        end else begin
                            w_col_nxt = r_col - 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_BLANK, ST_WRITE_BS: begin
                // A clear arriving here waits for the in-flight write to land first.
                if (i_clear_req) w_pend_nxt = 1'b1;
                if (i_vblank) begin
                    w_wr_en_nxt = 1'b1;
                    w_addr_nxt  = w_cur_addr;
                    w_data_nxt  = (r_state == ST_WAIT_BLANK) ? r_char : CHAR_SPACE;
                    if (r_state == ST_WAIT_BLANK) begin
                        if (r_col == COL_W'(COLS - 1)) begin
                            if (r_row == ROW_W'(ROWS - 1)) begin
                                w_pf_nxt = 1'b1;
                            end else begin
                                w_row_nxt = r_row + 1'b1;
                                w_col_nxt = '0;
                            end
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                    end
                end
            end
            ST_CLEAR: begin
                w_wr_en_nxt = w_step;
                if (w_step) begin
                    w_addr_nxt = w_sweep_idx;
                    w_data_nxt = CHAR_SPACE;
                end
                if (w_done) begin
                    w_row_nxt  = '0;
                    w_col_nxt  = '0;
                    w_pf_nxt   = 1'b0;
                    w_pend_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule
